// File: rtl/floppy_timer_irq.sv
// floppy_timer_irq
//   CPU-side front end for the floppy controller's 100 Hz countdown timer.
//   The block decodes four CPU registers and drives the timer's load port.
//   It watches the timer count, flags expiry as a pending interrupt, and can
//   reload the timer automatically to produce periodic ticks.
//
// Ports
//   clk_i       system clock (single domain)
//   reset_i     synchronous, active-high reset
//   addr_i[1:0] register select: 0 COUNT, 1 CTRL, 2 RELOAD, 3 STATUS
//   di_i[7:0]   CPU write data
//   wr_i        CPU write strobe (one cycle per access)
//   rd_i        CPU read strobe (one cycle per access)
//   do_o[7:0]   registered read data; holds until the next rd_i
//   irq_ack_i   interrupt acknowledge pulse; clears PEND
//   irq_o       interrupt request level = PEND & IEN
//   tmr_di_o    load value for the timer
//   tmr_wren_o  one-cycle load strobe for the timer
//   tmr_q_i     current timer count
//
// Optional feature
//   TIMER_IRQ_OVERRUN_EN: a 4-bit saturating overrun counter in STATUS[7:4].
//   It counts expiries that find PEND already set.

module floppy_timer_irq #(
    parameter logic [7:0] RELOAD_RST = 8'h00,
    parameter logic [7:0] CTRL_RST   = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] addr_i,
    input  logic [7:0] di_i,
    input  logic       wr_i,
    input  logic       rd_i,
    output logic [7:0] do_o,
    input  logic       irq_ack_i,
    output logic       irq_o,
    output logic [7:0] tmr_di_o,
    output logic       tmr_wren_o,
    input  logic [7:0] tmr_q_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ARMED  = 2'd2;
    localparam logic [1:0] ST_EXPIRE = 2'd3;

    localparam logic [1:0] A_COUNT  = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_RELOAD = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] tmr_di_q, tmr_di_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic [7:0] reload_q, reload_d;
    logic       pend_q, pend_d;
    logic [7:0] do_q, do_d;
    logic [3:0] ovr;
    logic [7:0] rdata;

    logic wr_count, wr_ctrl, wr_reload, wr_status, expire, armed;

    assign wr_count  = wr_i && (addr_i == A_COUNT);
    assign wr_ctrl   = wr_i && (addr_i == A_CTRL);
    assign wr_reload = wr_i && (addr_i == A_RELOAD);
    assign wr_status = wr_i && (addr_i == A_STATUS);
    assign expire    = (state_q == ST_EXPIRE);
    assign armed     = (state_q == ST_LOAD) || (state_q == ST_ARMED);

    // A CPU load takes priority over every FSM transition. This covers an
    // auto-reload issued from EXPIRE in the same cycle.
    always_comb begin
        state_d  = state_q;
        tmr_di_d = tmr_di_q;
        case (state_q)
            ST_LOAD:   state_d = (tmr_di_q != 8'h00) ? ST_ARMED : ST_IDLE;
            ST_ARMED:  if (tmr_q_i == 8'h00) state_d = ST_EXPIRE;
            ST_EXPIRE: begin
                if (ctrl_q[1] && (reload_q != 8'h00)) begin
                    state_d  = ST_LOAD;
                    tmr_di_d = reload_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
        if (wr_count) begin
            state_d  = ST_LOAD;
            tmr_di_d = di_i;
        end
    end

    always_comb begin
        ctrl_d   = wr_ctrl   ? di_i[1:0] : ctrl_q;
        reload_d = wr_reload ? di_i      : reload_q;
        // When a clear and an expiry occur in the same cycle, the expiry wins.
        pend_d = pend_q;
        if ((wr_status && di_i[0]) || irq_ack_i) pend_d = 1'b0;
        if (expire) pend_d = 1'b1;
    end

`ifdef TIMER_IRQ_OVERRUN_EN
    logic [3:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (wr_status && di_i[1]) ovr_d = '0;
        if (expire && pend_q && (ovr_d != 4'hF)) ovr_d = ovr_d + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ovr_q <= '0;
        else         ovr_q <= ovr_d;
    end

    assign ovr = ovr_q;
`else
    assign ovr = '0;
`endif

    // Reads use pre-write register values, so a same-cycle rd and wr returns
    // the old contents.
    always_comb begin
        case (addr_i)
            A_COUNT:  rdata = tmr_q_i;
            A_CTRL:   rdata = {6'b000000, ctrl_q};
            A_RELOAD: rdata = reload_q;
            default:  rdata = {ovr, 2'b00, armed, pend_q};
        endcase
        do_d = rd_i ? rdata : do_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            tmr_di_q <= '0;
            ctrl_q   <= CTRL_RST[1:0];
            reload_q <= RELOAD_RST;
            pend_q   <= 1'b0;
            do_q     <= '0;
        end else begin
            state_q  <= state_d;
            tmr_di_q <= tmr_di_d;
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            pend_q   <= pend_d;
            do_q     <= do_d;
        end
    end

    assign do_o       = do_q;
    assign irq_o      = pend_q & ctrl_q[0];
    assign tmr_di_o   = tmr_di_q;
    assign tmr_wren_o = (state_q == ST_LOAD);

endmodule

// File: tb/tb_floppy_timer_irq.sv
// tb_floppy_timer_irq
//   Directed bench for floppy_timer_irq. A simple timer model loads on
//   tmr_wren and otherwise counts down by one per clock until it reaches zero.
//   Inputs change 1 ns after the rising edge, and outputs are sampled at that
//   same point.

module tb_floppy_timer_irq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] addr = '0;
    logic [7:0] di = '0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] dout;
    logic       irq_ack = 1'b0;
    logic       irq;
    logic [7:0] tmr_di;
    logic       tmr_wren;
    logic [7:0] tmr_q;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  rv;
    int unsigned pulses;

    always #5 clk = ~clk;

    floppy_timer_irq #(
        .RELOAD_RST(8'h5A),
        .CTRL_RST  (8'h00)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .addr_i    (addr),
        .di_i      (di),
        .wr_i      (wr),
        .rd_i      (rd),
        .do_o      (dout),
        .irq_ack_i (irq_ack),
        .irq_o     (irq),
        .tmr_di_o  (tmr_di),
        .tmr_wren_o(tmr_wren),
        .tmr_q_i   (tmr_q)
    );

    always_ff @(posedge clk) begin
        if (reset)              tmr_q <= '0;
        else if (tmr_wren)      tmr_q <= tmr_di;
        else if (tmr_q != 8'h0) tmr_q <= tmr_q - 8'h1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; di = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        d = dout;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset state.
        check_eq("rst_irq", irq, 0);
        check_eq("rst_wren", tmr_wren, 0);
        check_eq("rst_do", dout, 8'h00);
        cpu_rd(0, rv); check_eq("rst_count", rv, 8'h00);
        cpu_rd(1, rv); check_eq("rst_ctrl", rv, 8'h00);
        cpu_rd(2, rv); check_eq("rst_reload", rv, 8'h5A);
        cpu_rd(3, rv); check_eq("rst_status", rv, 8'h00);

        // CTRL upper bits read back as 0.
        cpu_wr(1, 8'hFF); cpu_rd(1, rv); check_eq("ctrl_mask", rv, 8'h03);
        cpu_wr(1, 8'h01);

        // One-shot load of COUNT=3 with IEN set.
        cpu_wr(0, 8'h03);
        check_eq("ld3_wren", tmr_wren, 1);
        check_eq("ld3_di", tmr_di, 8'h03);
        tick(); check_eq("ld3_wren_off", tmr_wren, 0);
        tick(); tick(); tick(); tick();
        check_eq("ld3_irq_expire", irq, 0);
        tick(); check_eq("ld3_irq", irq, 1);
        cpu_rd(3, rv); check_eq("ld3_status", rv, 8'h01);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_eq("ack_irq", irq, 0);

        // A COUNT=0 load passes through LOAD and then returns to IDLE.
        cpu_wr(0, 8'h00);
        check_eq("ld0_wren", tmr_wren, 1);
        cpu_rd(3, rv); check_eq("ld0_armed_load", rv, 8'h02);
        cpu_rd(3, rv); check_eq("ld0_armed_off", rv, 8'h00);
        check_eq("ld0_irq", irq, 0);

        // Auto-reload with a period of 5 cycles per expiry.
        cpu_wr(2, 8'h02);
        cpu_wr(1, 8'h03);
        cpu_wr(0, 8'h02);
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_eq($sformatf("auto_wren_%0d", i), tmr_wren, (i % 5 == 0) ? 1 : 0);
            if (tmr_wren) begin
                pulses++;
                check_eq($sformatf("auto_di_%0d", i), tmr_di, 8'h02);
            end
        end
        check_eq("auto_pulses", pulses, 3);
        cpu_wr(0, 8'h00);
        tick();
        cpu_rd(3, rv);
`ifdef TIMER_IRQ_OVERRUN_EN
        check_eq("auto_status", rv, 8'h21);
`else
        check_eq("auto_status", rv, 8'h01);
`endif
        check_eq("auto_irq", irq, 1);
        cpu_wr(3, 8'h02); cpu_rd(3, rv); check_eq("ovr_clr", rv, 8'h01);
        cpu_wr(3, 8'h01); cpu_rd(3, rv); check_eq("w1c_pend", rv, 8'h00);
        check_eq("w1c_irq", irq, 0);

        // An expiry and a PEND W1C in the same cycle leave PEND set.
        cpu_wr(1, 8'h01);
        cpu_wr(0, 8'h01);
        tick(); tick(); tick();
        cpu_wr(3, 8'h01);
        check_eq("race_irq", irq, 1);
        cpu_rd(3, rv); check_eq("race_status", rv, 8'h01);
        cpu_wr(1, 8'h00); check_eq("ien_off_irq", irq, 0);
        cpu_rd(3, rv); check_eq("ien_off_pend", rv, 8'h01);
        cpu_wr(1, 8'h01); check_eq("ien_on_irq", irq, 1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_eq("race_ack_irq", irq, 0);
        cpu_rd(3, rv); check_eq("race_ack_status", rv, 8'h00);

        // A CPU COUNT write in the EXPIRE cycle overrides the auto-reload.
        cpu_wr(1, 8'h03);
        cpu_wr(0, 8'h01);
        tick(); tick(); tick();
        cpu_wr(0, 8'h07);
        check_eq("ovr_ld_wren", tmr_wren, 1);
        check_eq("ovr_ld_di", tmr_di, 8'h07);
        tick();

        // Reset while ARMED with AUTO enabled.
        reset = 1'b1; tick();
        check_eq("mid_rst_wren", tmr_wren, 0);
        check_eq("mid_rst_irq", irq, 0);
        reset = 1'b0; tick();
        check_eq("post_rst_wren", tmr_wren, 0);
        cpu_rd(3, rv); check_eq("post_rst_status", rv, 8'h00);
        cpu_rd(1, rv); check_eq("post_rst_ctrl", rv, 8'h00);

        // rd and wr in the same cycle return the pre-write value; do holds.
        addr = 2; di = 8'h33; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        check_eq("rdwr_old", dout, 8'h5A);
        cpu_rd(2, rv); check_eq("rdwr_new", rv, 8'h33);
        tick(); tick(); check_eq("do_hold", dout, 8'h33);

        // COUNT reads return the live timer value; with IEN clear, irq stays low.
        cpu_wr(0, 8'h09);
        tick();
        cpu_rd(0, rv); check_eq("count_rd", rv, 8'h09);
        for (int i = 0; i < 15; i++) tick();
        check_eq("noien_irq", irq, 0);
        cpu_rd(3, rv); check_eq("noien_status", rv, 8'h01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
